// File: rtl/min_uint64_stream_reduce_if.sv
// Stream interface for min_uint64_stream_reduce.
// Carries the input word stream (valid/ready/data/last) and the per-frame result
// channel (valid/ready/min/index/count/ovf).
//   slave  : the reducer side (consumes words, produces results)
//   master : the producer/consumer side (drives words, accepts results)
interface min_uint64_stream_reduce_if #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_min;
    logic [CNT_WIDTH-1:0] out_index;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_ovf;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_min, out_index, out_count, out_ovf
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_min, out_index, out_count, out_ovf
    );
endinterface

// File: rtl/min_uint64_stream_reduce.sv
// Streaming min-reduction over frames of unsigned WIDTH-bit words.
// Each accepted beat is folded into a running minimum; the beat flagged in_last closes
// the frame and the result (minimum, index of its first occurrence, saturating beat count,
// overflow flag) is presented on the result channel until accepted.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   s_io   slave side of min_uint64_stream_reduce_if (input stream + result channel)
module min_uint64_stream_reduce #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned IMPL_TYPE = 0,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    min_uint64_stream_reduce_if.slave      s_io
);
    typedef enum logic [0:0] {StAccum, StResult} state_e;

    state_e               state_q;
    logic                 first_q;
    logic                 ovf_q;
    logic [WIDTH-1:0]     acc_q;
    logic [CNT_WIDTH-1:0] idx_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     out_min_q;
    logic [CNT_WIDTH-1:0] out_index_q;
    logic [CNT_WIDTH-1:0] out_count_q;
    logic                 out_ovf_q;

    logic                 gt;
    logic                 ovf_d;
    logic [WIDTH-1:0]     acc_d;
    logic [CNT_WIDTH-1:0] idx_d;
    logic [CNT_WIDTH-1:0] cnt_d;

    // gt = acc_q > in_data, unsigned; IMPL_TYPE selects the comparator structure.
    if (IMPL_TYPE == 0) begin : g_gt_direct
        assign gt = acc_q > s_io.in_data;
    end else begin : g_gt_borrow
        logic [WIDTH:0] diff;
        // in_data - acc borrows exactly when acc > in_data
        assign diff = {1'b0, s_io.in_data} - {1'b0, acc_q};
        assign gt   = diff[WIDTH];
    end

    // Fold of the current beat into the running state.
    always_comb begin
        acc_d = acc_q;
        idx_d = idx_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (first_q) begin
            acc_d = s_io.in_data;
            idx_d = '0;
            cnt_d = CNT_WIDTH'(1);
            ovf_d = 1'b0;
        end else begin
            if (gt) begin
                acc_d = s_io.in_data;
                // Past the count limit cnt_q no longer names the beat, so idx freezes.
                if (!ovf_q) begin
                    idx_d = cnt_q;
                end
            end
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StAccum;
            first_q     <= 1'b1;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_min_q   <= '0;
            out_index_q <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StAccum: begin
                    if (s_io.in_valid) begin
                        acc_q   <= acc_d;
                        idx_q   <= idx_d;
                        cnt_q   <= cnt_d;
                        ovf_q   <= ovf_d;
                        first_q <= 1'b0;
                        if (s_io.in_last) begin
                            out_min_q   <= acc_d;
                            out_index_q <= idx_d;
                            out_count_q <= cnt_d;
                            out_ovf_q   <= ovf_d;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state_q     <= StResult;
                        end
                    end
                end
                StResult: begin
                    // Result fields are left as-is after the handshake; only valid drops.
                    if (s_io.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        first_q     <= 1'b1;
                        ovf_q       <= 1'b0;
                        state_q     <= StAccum;
                    end
                end
                default: state_q <= StAccum;
            endcase
        end
    end

    assign s_io.in_ready  = in_ready_q;
    assign s_io.out_valid = out_valid_q;
    assign s_io.out_min   = out_min_q;
    assign s_io.out_index = out_index_q;
    assign s_io.out_count = out_count_q;
    assign s_io.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_min_uint64_stream_reduce.sv
module tb_min_uint64_stream_reduce;
    localparam logic [63:0] AllOnes = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    min_uint64_stream_reduce_if #(.WIDTH(64), .CNT_WIDTH(16)) bus ();
    min_uint64_stream_reduce_if #(.WIDTH(64), .CNT_WIDTH(4))  sbus ();

    min_uint64_stream_reduce #(.WIDTH(64), .IMPL_TYPE(0), .CNT_WIDTH(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_io  (bus)
    );

    min_uint64_stream_reduce #(.WIDTH(64), .IMPL_TYPE(0), .CNT_WIDTH(4)) u_dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .s_io  (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat on the main DUT, accepted at the next edge (DUT is in ACCUM).
    task automatic beat(input logic [63:0] d, input logic l);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic sbeat(input logic [63:0] d, input logic l);
        sbus.in_valid = 1'b1;
        sbus.in_data  = d;
        sbus.in_last  = l;
        tick();
        sbus.in_valid = 1'b0;
        sbus.in_last  = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [63:0] mn, input logic [15:0] ix,
                             input logic [15:0] ct);
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, ".ready"}, 64'(bus.in_ready), 64'd0);
        chk({tag, ".min"}, bus.out_min, mn);
        chk({tag, ".index"}, 64'(bus.out_index), 64'(ix));
        chk({tag, ".count"}, 64'(bus.out_count), 64'(ct));
        chk({tag, ".ovf"}, 64'(bus.out_ovf), 64'd0);
    endtask

    task automatic accept(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, ".valid_drop"}, 64'(bus.out_valid), 64'd0);
        chk({tag, ".ready_back"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;  bus.in_data = '0;  bus.in_last = 1'b0;  bus.out_ready = 1'b0;
        sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.in_last = 1'b0; sbus.out_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.out_min", bus.out_min, 64'd0);
        chk("rst.out_index", 64'(bus.out_index), 64'd0);
        chk("rst.out_count", 64'(bus.out_count), 64'd0);
        chk("rst.out_ovf", 64'(bus.out_ovf), 64'd0);

        // Frame 5,3,9,3: tie on 3 keeps the earlier index 1
        beat(64'd5, 1'b0);
        beat(64'd3, 1'b0);
        beat(64'd9, 1'b0);
        chk("f1.no_early_valid", 64'(bus.out_valid), 64'd0);
        beat(64'd3, 1'b1);
        check_res("f1", 64'd3, 16'd1, 16'd4);
        accept("f1");
        chk("f1.min_held", bus.out_min, 64'd3);
        chk("f1.count_held", 64'(bus.out_count), 64'd4);

        // Single all-ones beat, then hold out_ready low with in_valid pulses offered
        beat(AllOnes, 1'b1);
        check_res("f2", AllOnes, 16'd0, 16'd1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.in_data  = 64'd0;
            bus.in_last  = 1'b1;
            tick();
            chk("hold.in_ready", 64'(bus.in_ready), 64'd0);
            chk("hold.valid", 64'(bus.out_valid), 64'd1);
            chk("hold.min", bus.out_min, AllOnes);
            chk("hold.count", 64'(bus.out_count), 64'd1);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        accept("f2");
        beat(64'd0, 1'b1);
        check_res("f3", 64'd0, 16'd0, 16'd1);
        accept("f3");

        // Back-to-back frames with idle gaps; idle cycles carry junk data/last
        beat(64'd7, 1'b0);
        bus.in_data = 64'd0;
        bus.in_last = 1'b1;
        repeat (2) tick();
        beat(64'd2, 1'b1);
        check_res("f4", 64'd2, 16'd1, 16'd2);
        accept("f4");
        bus.in_data = 64'd0;
        bus.in_last = 1'b1;
        tick();
        bus.in_last = 1'b0;
        beat(64'd1, 1'b1);
        check_res("f5", 64'd1, 16'd0, 16'd1);
        accept("f5");

        // Top bit set must compare as a large unsigned value
        beat(64'd1, 1'b0);
        beat(64'h8000_0000_0000_0000, 1'b1);
        check_res("f6", 64'd1, 16'd0, 16'd2);
        accept("f6");

        // Count saturation on the 4-bit instance: 20 beats, earlier min at 3, true min at 17
        for (int i = 0; i < 20; i++) begin
            logic [63:0] d;
            d = 64'd50;
            if (i == 3)  d = 64'd20;
            if (i == 17) d = 64'd5;
            sbeat(d, i == 19);
        end
        chk("sat.valid", 64'(sbus.out_valid), 64'd1);
        chk("sat.min", sbus.out_min, 64'd5);
        chk("sat.count", 64'(sbus.out_count), 64'd15);
        chk("sat.ovf", 64'(sbus.out_ovf), 64'd1);
        chk("sat.index_frozen", 64'(sbus.out_index), 64'd3);
        sbus.out_ready = 1'b1;
        tick();
        sbus.out_ready = 1'b0;
        sbeat(64'd9, 1'b1);
        chk("sat2.ovf_cleared", 64'(sbus.out_ovf), 64'd0);
        chk("sat2.count", 64'(sbus.out_count), 64'd1);
        chk("sat2.min", sbus.out_min, 64'd9);

        // Reset mid-frame after 3 beats discards the partial minimum
        beat(64'd4, 1'b0);
        beat(64'd0, 1'b0);
        beat(64'd8, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst.out_min", bus.out_min, 64'd0);
        chk("mrst.out_index", 64'(bus.out_index), 64'd0);
        chk("mrst.out_count", 64'(bus.out_count), 64'd0);
        chk("mrst.small_min", sbus.out_min, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        beat(64'd6, 1'b0);
        beat(64'd7, 1'b1);
        check_res("f7", 64'd6, 16'd0, 16'd2);
        accept("f7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
